// File: rtl/pipeline_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_unit_pkg
// Forward-select encodings and scoreboard entry bit layout for the hazard unit.
// Revision: 1.0
// ============================================================================
package pipeline_hazard_unit_pkg;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // Entry layout: {waddr, mem_op, is_load, wen, valid}, waddr at ENT_ADDR upward
    localparam int ENT_VALID = 0;
    localparam int ENT_WEN   = 1;
    localparam int ENT_LOAD  = 2;
    localparam int ENT_MEMOP = 3;
    localparam int ENT_ADDR  = 4;

    function automatic logic [1:0] fwd_pick(input logic i_mem_hit, input logic i_wb_hit);
        if (i_mem_hit)
            return FWD_EXMEM;
        else if (i_wb_hit)
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_unit_match.sv
`default_nettype none
// ============================================================================
// hazard_match
// Combinational source-vs-scoreboard-entry comparator; register 0 never hits.
// Revision: 1.0
// ============================================================================
module hazard_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_use,
    input  logic              i_valid,
    input  logic              i_wen,
    input  logic [REG_AW-1:0] i_waddr,
    output logic              o_match
);

    assign o_match = i_use && i_valid && i_wen &&
                     (i_waddr == i_src) && (i_src != '0);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_unit
// Interlock / forwarding / stall controller with shadow scoreboard and
// multi-cycle memory freeze for the 5-stage pipeline.
// Revision: 1.0
// ============================================================================
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter bit FWD_EN  = 1'b1,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              cpu_rst,
    input  logic              cpu_en,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wen,
    input  logic [REG_AW-1:0] id_waddr,
    input  logic              id_is_load,
    input  logic              id_mem_op,
    input  logic              id_is_branch,
    input  logic              id_redirect,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              freeze_all,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [1:0]        id_fwd_rs_sel,
    output logic [1:0]        id_fwd_rt_sel
);

    localparam int         c_EW     = ENT_ADDR + REG_AW;
    localparam logic [3:0] c_LAT_M1 = 4'(MEM_LAT - 1);

    logic [c_EW-1:0]   r_ex, r_mem, r_wb;
    logic [REG_AW-1:0] r_ex_rs, r_ex_rt;
    logic              r_ex_use_rs, r_ex_use_rt;
    logic [3:0]        r_cnt;

    logic [c_EW-1:0]   w_id_ent;
    logic              w_freeze;
    logic              w_data_stall;
    logic              w_unused;

    // Sources: 0 id_rs, 1 id_rt, 2 ex_rs, 3 ex_rt.  Entries: 0 EX, 1 MEM, 2 WB.
    logic [REG_AW-1:0] w_src [4];
    logic              w_use [4];
    logic [c_EW-1:0]   w_ent [3];
    logic [2:0]        w_m   [4];

    assign w_id_ent = {id_waddr, id_mem_op, id_is_load, id_wen, 1'b1};
    assign w_src[0] = id_rs;
    assign w_src[1] = id_rt;
    assign w_src[2] = r_ex_rs;
    assign w_src[3] = r_ex_rt;
    assign w_use[0] = id_use_rs;
    assign w_use[1] = id_use_rt;
    assign w_use[2] = r_ex_use_rs;
    assign w_use[3] = r_ex_use_rt;
    assign w_ent[0] = r_ex;
    assign w_ent[1] = r_mem;
    assign w_ent[2] = r_wb;
    assign w_unused = &{1'b0, r_wb[ENT_LOAD], r_wb[ENT_MEMOP]};

    generate
        for (genvar s = 0; s < 4; s++) begin : g_src
            for (genvar e = 0; e < 3; e++) begin : g_ent
                if (s >= 2 && e == 0) begin : g_none
                    assign w_m[s][e] = 1'b0;
                end else begin : g_cmp
                    hazard_match #(.REG_AW(REG_AW)) u_match (
                        .i_src   (w_src[s]),
                        .i_use   (w_use[s]),
                        .i_valid (w_ent[e][ENT_VALID]),
                        .i_wen   (w_ent[e][ENT_WEN]),
                        .i_waddr (w_ent[e][ENT_ADDR +: REG_AW]),
                        .o_match (w_m[s][e])
                    );
                end
            end
        end
    endgenerate

    // Memory op occupies MEM for MEM_LAT cycles; MEM_LAT=1 gives c_LAT_M1=0, never freezes
    assign w_freeze = r_mem[ENT_VALID] && r_mem[ENT_MEMOP] && (r_cnt < c_LAT_M1);

    generate
        if (FWD_EN) begin : g_fwd_on
            logic w_hit_ex, w_hit_mem;
            assign w_hit_ex  = w_m[0][0] | w_m[1][0];
            assign w_hit_mem = w_m[0][1] | w_m[1][1];
            assign w_data_stall = (w_hit_ex && r_ex[ENT_LOAD]) ||
                                  (id_is_branch && w_hit_ex) ||
                                  (id_is_branch && w_hit_mem && r_mem[ENT_LOAD]);
            assign fwd_a_sel     = fwd_pick(w_m[2][1], w_m[2][2]);
            assign fwd_b_sel     = fwd_pick(w_m[3][1], w_m[3][2]);
            assign id_fwd_rs_sel = fwd_pick(w_m[0][1] && !r_mem[ENT_LOAD], w_m[0][2]);
            assign id_fwd_rt_sel = fwd_pick(w_m[1][1] && !r_mem[ENT_LOAD], w_m[1][2]);
        end else begin : g_fwd_off
            logic w_unused_ex;
            assign w_unused_ex  = &{1'b0, w_m[2], w_m[3]};
            assign w_data_stall = (|w_m[0]) | (|w_m[1]);
            assign fwd_a_sel     = FWD_REG;
            assign fwd_b_sel     = FWD_REG;
            assign id_fwd_rs_sel = FWD_REG;
            assign id_fwd_rt_sel = FWD_REG;
        end
    endgenerate

    assign freeze_all  = w_freeze;
    assign stall_pc    = w_data_stall && !w_freeze;
    assign stall_ifid  = w_data_stall && !w_freeze;
    assign bubble_idex = w_data_stall && !w_freeze;
    assign flush_ifid  = id_redirect && !w_data_stall && !w_freeze;

    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_use_rs <= 1'b0;
            r_ex_use_rt <= 1'b0;
            r_cnt       <= 4'd0;
        end else if (cpu_en) begin
            if (w_freeze) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
                r_wb  <= r_mem;
                r_mem <= r_ex;
                if (w_data_stall) begin
                    r_ex        <= '0;
                    r_ex_rs     <= '0;
                    r_ex_rt     <= '0;
                    r_ex_use_rs <= 1'b0;
                    r_ex_use_rt <= 1'b0;
                end else begin
                    r_ex        <= w_id_ent;
                    r_ex_rs     <= id_rs;
                    r_ex_rt     <= id_rt;
                    r_ex_use_rs <= id_use_rs;
                    r_ex_use_rt <= id_use_rt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_unit
// Three configurations (forwarding, interlock, MEM_LAT=3) against a pipeline model.
// Revision: 1.0
// ============================================================================
module tb_pipeline_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       cpu_rst, cpu_en;
    logic [4:0] id_rs, id_rt, id_waddr;
    logic       id_use_rs, id_use_rt, id_wen, id_is_load, id_mem_op, id_is_branch, id_redirect;

    // {stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze_all, fwd_a, fwd_b, id_rs, id_rt}
    logic [12:0] obs [3];
    int compared   = 0;
    int mismatched = 0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            logic       sp, si, bi, fl, fz;
            logic [1:0] fa, fb, fr, ft;
            pipeline_hazard_unit #(.REG_AW(5), .FWD_EN(g != 1), .MEM_LAT((g == 2) ? 3 : 1)) u_dut (
                .clk(clk), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
                .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
                .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
                .id_mem_op(id_mem_op), .id_is_branch(id_is_branch), .id_redirect(id_redirect),
                .stall_pc(sp), .stall_ifid(si), .bubble_idex(bi), .flush_ifid(fl),
                .freeze_all(fz), .fwd_a_sel(fa), .fwd_b_sel(fb),
                .id_fwd_rs_sel(fr), .id_fwd_rt_sel(ft)
            );
            assign obs[g] = {sp, si, bi, fl, fz, fa, fb, fr, ft};
        end
    endgenerate

    // Model: instructions in flight per configuration, plus memory-wait count
    typedef struct {
        bit v, wen, ld, mo;
        int wa, rs, rt;
        bit urs, urt;
    } ent_t;

    ent_t m_ex [3], m_mem [3], m_wb [3];
    int   m_cnt [3];

    function automatic bit hit(ent_t e, int src, bit u);
        return u && e.v && e.wen && (e.wa == src) && (src != 0);
    endfunction

    function automatic bit m_frz(int k);
        int lat = (k == 2) ? 3 : 1;
        return m_mem[k].v && m_mem[k].mo && (m_cnt[k] < lat - 1);
    endfunction

    function automatic bit m_ds(int k);
        bit rs_ex  = hit(m_ex[k],  int'(id_rs), id_use_rs);
        bit rt_ex  = hit(m_ex[k],  int'(id_rt), id_use_rt);
        bit rs_mem = hit(m_mem[k], int'(id_rs), id_use_rs);
        bit rt_mem = hit(m_mem[k], int'(id_rt), id_use_rt);
        bit rs_wb  = hit(m_wb[k],  int'(id_rs), id_use_rs);
        bit rt_wb  = hit(m_wb[k],  int'(id_rt), id_use_rt);
        if (k == 1)
            return rs_ex || rt_ex || rs_mem || rt_mem || rs_wb || rt_wb;
        return ((rs_ex || rt_ex) && m_ex[k].ld) ||
               (id_is_branch && (rs_ex || rt_ex)) ||
               (id_is_branch && (rs_mem || rt_mem) && m_mem[k].ld);
    endfunction

    function automatic logic [1:0] pick(bit from_mem, bit from_wb);
        if (from_mem) return 2'd1;
        if (from_wb)  return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [12:0] model_out(int k);
        bit frz = m_frz(k);
        bit ds  = m_ds(k);
        bit st  = ds && !frz;
        bit fl  = id_redirect && !ds && !frz;
        logic [1:0] fa = 2'd0, fb = 2'd0, fr = 2'd0, ft = 2'd0;
        if (k != 1) begin
            fa = pick(hit(m_mem[k], m_ex[k].rs, m_ex[k].urs), hit(m_wb[k], m_ex[k].rs, m_ex[k].urs));
            fb = pick(hit(m_mem[k], m_ex[k].rt, m_ex[k].urt), hit(m_wb[k], m_ex[k].rt, m_ex[k].urt));
            fr = pick(hit(m_mem[k], int'(id_rs), id_use_rs) && !m_mem[k].ld,
                      hit(m_wb[k], int'(id_rs), id_use_rs));
            ft = pick(hit(m_mem[k], int'(id_rt), id_use_rt) && !m_mem[k].ld,
                      hit(m_wb[k], int'(id_rt), id_use_rt));
        end
        return {st, st, st, fl, frz, fa, fb, fr, ft};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ex[k]  = '{default: 0};
            m_mem[k] = '{default: 0};
            m_wb[k]  = '{default: 0};
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_adv();
        if (cpu_rst) begin
            model_reset();
        end else if (cpu_en) begin
            for (int k = 0; k < 3; k++) begin
                if (m_frz(k)) begin
                    m_cnt[k]++;
                end else begin
                    bit ds = m_ds(k);
                    m_cnt[k] = 0;
                    m_wb[k]  = m_mem[k];
                    m_mem[k] = m_ex[k];
                    if (ds)
                        m_ex[k] = '{default: 0};
                    else
                        m_ex[k] = '{v: 1'b1, wen: id_wen, ld: id_is_load, mo: id_mem_op,
                                    wa: int'(id_waddr), rs: int'(id_rs), rt: int'(id_rt),
                                    urs: id_use_rs, urt: id_use_rt};
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic [12:0] exp = model_out(k);
            compared++;
            assert (obs[k] === exp) else begin
                mismatched++;
                $error("FAIL cfg%0d outputs: got=%b required=%b", k, obs[k], exp);
            end
        end
    endtask

    task automatic chk(string tag, int got, int exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got=%0d required=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic set_id(bit wen, int wa, int rs, int rt, bit urs, bit urt, bit ld, bit mo, bit br);
        id_wen = wen; id_waddr = 5'(wa); id_rs = 5'(rs); id_rt = 5'(rt);
        id_use_rs = urs; id_use_rt = urt; id_is_load = ld; id_mem_op = mo;
        id_is_branch = br; id_redirect = 1'b0;
    endtask

    task automatic set_alu(int wd, int rs, int rt); set_id(1, wd, rs, rt, 1, 1, 0, 0, 0); endtask
    task automatic set_lw(int wd, int b);           set_id(1, wd, b, wd, 1, 0, 1, 1, 0); endtask
    task automatic set_sw(int b, int d);            set_id(0, 0, b, d, 1, 1, 0, 1, 0);   endtask
    task automatic set_beq(int a, int b);           set_id(0, 0, a, b, 1, 1, 0, 0, 1);   endtask
    task automatic set_nop();                       set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);   endtask

    task automatic nops(int n);
        set_nop();
        repeat (n) begin step(); tick(); end
    endtask

    initial begin
        cpu_rst = 1'b1; cpu_en = 1'b1;
        set_nop();
        model_reset();
        @(posedge clk); #1;
        step();
        chk("reset_cfg0", int'(obs[0]), 0);
        chk("reset_cfg2", int'(obs[2]), 0);
        tick();
        cpu_rst = 1'b0;
        nops(2);

        // add $1 then sub $4,$1,$5
        set_alu(1, 2, 3); step(); tick();
        set_alu(4, 1, 5); step();
        chk("addsub_nostall", int'(obs[0][12]), 0);
        chk("ilk_stall", int'(obs[1][12]), 1);
        tick();
        set_nop(); step();
        chk("addsub_fwd_a", int'(obs[0][7:6]), 1);
        chk("ilk_fwd_zero", int'(obs[1][7:0]), 0);
        tick();

        // same pair with a nop between
        nops(3);
        set_alu(1, 2, 3); step(); tick();
        set_nop();        step(); tick();
        set_alu(4, 1, 5); step(); tick();
        set_nop(); step();
        chk("gap_fwd_a", int'(obs[0][7:6]), 2);
        tick();

        // load-use
        nops(3);
        set_lw(1, 0); step(); tick();
        set_alu(4, 1, 1); step();
        chk("lw_use_stall", int'(obs[0][12:10]), 7);
        tick(); step();
        chk("lw_use_release", int'(obs[0][12]), 0);
        tick();
        set_nop(); step();
        chk("lw_fwd_ab", int'(obs[0][7:4]), 4'b1010);
        tick();

        // alu then branch
        nops(3);
        set_alu(1, 2, 3); step(); tick();
        set_beq(1, 2); step();
        chk("br_alu_stall", int'(obs[0][12]), 1);
        tick(); step();
        chk("br_alu_release", int'(obs[0][12]), 0);
        chk("br_alu_fwd", int'(obs[0][3:2]), 1);
        tick();

        // load then branch
        nops(3);
        set_lw(1, 0); step(); tick();
        set_beq(1, 2); step();
        chk("br_lw_stall1", int'(obs[0][12]), 1);
        tick(); step();
        chk("br_lw_stall2", int'(obs[0][12]), 1);
        tick(); step();
        chk("br_lw_release", int'(obs[0][12]), 0);
        chk("br_lw_fwd", int'(obs[0][3:2]), 2);
        tick();

        // register 0
        nops(3);
        set_alu(0, 2, 3); step(); tick();
        set_alu(4, 0, 0); step();
        chk("zero_ilk_nostall", int'(obs[1][12]), 0);
        chk("zero_id_sel", int'(obs[0][3:0]), 0);
        tick();
        set_nop(); step();
        chk("zero_ex_sel", int'(obs[0][7:4]), 0);
        tick();

        // multi-cycle store with redirect during freeze
        nops(4);
        set_sw(2, 3); step(); tick();
        set_nop();    step(); tick();
        id_redirect = 1'b1; step();
        chk("frz_on1", int'(obs[2][8]), 1);
        chk("frz_noflush", int'(obs[2][9]), 0);
        chk("flush_cfg0", int'(obs[0][9]), 1);
        tick(); step();
        chk("frz_on2", int'(obs[2][8]), 1);
        tick();
        id_redirect = 1'b0; step();
        chk("frz_off", int'(obs[2][8]), 0);
        tick();

        // reset in the middle of a freeze
        nops(4);
        set_sw(2, 3); step(); tick();
        set_nop();    step(); tick();
        step();
        chk("frz_again", int'(obs[2][8]), 1);
        #1 cpu_rst = 1'b1;
        model_reset();
        #1 check_all();
        chk("rst_midfreeze", int'(obs[2]), 0);
        tick();
        cpu_rst = 1'b0;
        step();
        chk("post_rst_quiet", int'(obs[2]), 0);
        tick();

        // randomized traffic on a small register set
        repeat (600) begin
            int op = int'($urandom_range(0, 5));
            int a  = int'($urandom_range(0, 3));
            int b  = int'($urandom_range(0, 3));
            int d  = int'($urandom_range(0, 3));
            case (op)
                0:       set_alu(d, a, b);
                1:       set_lw(d, a);
                2:       set_sw(a, b);
                3:       set_beq(a, b);
                4:       set_id(0, 0, a, 0, 1, 0, 0, 0, 1);
                default: set_nop();
            endcase
            id_redirect = (op == 3 || op == 4) && ($urandom_range(0, 1) != 0);
            cpu_en  = ($urandom_range(0, 7) != 0);
            cpu_rst = ($urandom_range(0, 63) == 0);
            if (cpu_rst) model_reset();
            step();
            tick();
        end
        cpu_rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
